// File: rtl/gfx_fifo_level_pkg.sv
// Shared helpers for the gfx_fifo_level FIFO.
// Holds the pointer-width function used to size the RAM address for any depth.
package gfx_fifo_level_pkg;

   // A one-entry RAM still needs a 1-bit address, so the width never drops to zero.
   function automatic int unsigned ptr_width(input int unsigned entries);
      return (entries <= 1) ? 1 : $clog2(entries);
   endfunction

endpackage

// File: rtl/gfx_fifo_ram.sv
// Simple dual-port storage for gfx_fifo_level.
// The registered read port doubles as the FIFO's output data register.
module gfx_fifo_ram
   import gfx_fifo_level_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ENTRIES = 15,
   parameter int PTR_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rd_en_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [ENTRIES];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[waddr_i] <= wdata_i;
   end

   // Only the read register is reset so the head word reads as zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rdata_q <= '0;
      else if (rd_en_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/gfx_fifo_level.sv
// Single-clock FIFO with level, registered almost-full/almost-empty flags and flush.
// Define GFX_FIFO_BYPASS_EN to let a push into an empty FIFO skip the RAM (1-edge latency).
module gfx_fifo_level
   import gfx_fifo_level_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 16,
   parameter int ALMOST_FULL  = DEPTH - 2,
   parameter int ALMOST_EMPTY = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       almost_full,
   output logic                       almost_empty
);

   localparam int PTR_W = int'(ptr_width(DEPTH - 1));
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 2);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(ALMOST_FULL);
   localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(ALMOST_EMPTY);

   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             out_valid_q, out_valid_d;
   logic             af_q, af_d, ae_q, ae_d;
   logic             push, pop, ram_empty, load, byp, wr_en;
   logic [WIDTH-1:0] ram_rdata;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = !flush && (level_q < LVL_FULL);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid_q && out_ready;
   // The output register holds one of the counted words; the rest live in RAM.
   assign ram_empty = (level_q == LVL_W'(out_valid_q));
   assign load      = !flush && !ram_empty && (!out_valid_q || pop);

`ifdef GFX_FIFO_BYPASS_EN
   logic [WIDTH-1:0] byp_q;
   logic             sel_q;

   assign byp = push && ram_empty && (!out_valid_q || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byp_q <= '0;
         sel_q <= 1'b0;
      end else if (byp) begin
         byp_q <= in;
         sel_q <= 1'b1;
      end else if (load) begin
         sel_q <= 1'b0;
      end
   end

   assign out = sel_q ? byp_q : ram_rdata;
`else
   assign byp = 1'b0;
   assign out = ram_rdata;
`endif

   assign wr_en = push && !byp;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      level_d     = level_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         level_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (wr_en) wptr_d = ptr_inc(wptr_q);
         if (load)  rptr_d = ptr_inc(rptr_q);
         if (load || byp) out_valid_d = 1'b1;
         else if (pop)    out_valid_d = 1'b0;
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      end
      af_d = (level_d >= AF_LVL);
      ae_d = (level_d <= AE_LVL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         af_q        <= 1'b0;
         ae_q        <= 1'b1;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         af_q        <= af_d;
         ae_q        <= ae_d;
      end
   end

   gfx_fifo_ram #(
      .WIDTH  (WIDTH),
      .ENTRIES(DEPTH - 1),
      .PTR_W  (PTR_W)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .wr_en_i(wr_en),
      .waddr_i(wptr_q),
      .wdata_i(in),
      .rd_en_i(load),
      .raddr_i(rptr_q),
      .rdata_o(ram_rdata)
   );

   assign out_valid    = out_valid_q;
   assign level        = level_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;

endmodule

// File: tb/tb_gfx_fifo_level.sv
// Self-checking bench for gfx_fifo_level (WIDTH=8, DEPTH=5, ALMOST_FULL=4, ALMOST_EMPTY=1).
// Reference model: a queue for the RAM plus one output slot, stepped once per clock edge.
module tb_gfx_fifo_level;

`ifdef GFX_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, flush, in_valid, out_ready;
   logic       in_ready, out_valid, almost_full, almost_empty;
   logic [7:0] din, dout;
   logic [2:0] level;

   gfx_fifo_level #(.WIDTH(8), .DEPTH(5), .ALMOST_FULL(4), .ALMOST_EMPTY(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in(din), .in_valid(in_valid),
      .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out(dout),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] m_q[$];
   logic       m_ov;
   logic [7:0] m_od;
   int         m_lvl;
   logic [7:0] got[$];

   task automatic model_reset();
      m_q.delete();
      m_ov  = 1'b0;
      m_od  = 8'h00;
      m_lvl = 0;
   endtask

   task automatic model_edge(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      bit pop, push, byp_take;
      byp_take = 1'b0;
      pop  = m_ov && ordy;
      push = iv && !fl && (m_lvl < 5);
      if (fl) begin
         m_q.delete();
         m_ov  = 1'b0;
         m_lvl = 0;
         return;
      end
      if (!m_ov || pop) begin
         if (m_q.size() != 0) begin
            m_od = m_q.pop_front();
            m_ov = 1'b1;
         end else if (BYP && push) begin
            m_od = d;
            m_ov = 1'b1;
            byp_take = 1'b1;
         end else begin
            m_ov = 1'b0;
         end
      end
      if (push && !byp_take) m_q.push_back(d);
      m_lvl = m_lvl + int'(push) - int'(pop);
   endtask

   function automatic logic [6:0] exp_status();
      return {m_ov, 3'(m_lvl), (m_lvl >= 4), (m_lvl <= 1), ((m_lvl < 5) && !flush)};
   endfunction

   task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      din       = d;
      out_ready = ordy;
      flush     = fl;
      if (out_valid && ordy) got.push_back(dout);
      @(posedge clk);
      model_edge(iv, d, ordy, fl);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, level, almost_full, almost_empty, in_ready, dout} !== {7'b0_000_0_1_1, 8'h00}) begin
         errors++;
         $display("FAIL reset_values: got %b/%h want 0000011/00",
                  {out_valid, level, almost_full, almost_empty, in_ready}, dout);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_first_word();
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== BYP) begin
         errors++;
         $display("FAIL first_word_e0: out_valid got %b want %b", out_valid, BYP);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      vectors++;
      if ({out_valid, dout, level, almost_empty} !== {1'b1, 8'h11, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL first_word_e1: got v=%b out=%h lvl=%0d ae=%b want v=1 out=11 lvl=1 ae=1",
                  out_valid, dout, level, almost_empty);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if ({out_valid, level, almost_full, almost_empty, in_ready} !== exp_status()) begin
         errors++;
         $display("FAIL first_word_drain: got %b want %b",
                  {out_valid, level, almost_full, almost_empty, in_ready}, exp_status());
      end
   endtask

   task automatic test_fill();
      got.delete();
      for (int i = 1; i <= 6; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0);
         vectors++;
         if ({out_valid, level, almost_full, almost_empty, in_ready} !== exp_status()) begin
            errors++;
            $display("FAIL fill_status push%0d: got %b want %b", i,
                     {out_valid, level, almost_full, almost_empty, in_ready}, exp_status());
         end
         if (i == 4) begin
            vectors++;
            if (almost_full !== 1'b1) begin
               errors++;
               $display("FAIL fill_af_at4: got %b want 1", almost_full);
            end
         end
      end
      vectors++;
      if ({level, in_ready} !== {3'd5, 1'b0}) begin
         errors++;
         $display("FAIL fill_full: got lvl=%0d rdy=%b want lvl=5 rdy=0", level, in_ready);
      end
   endtask

   task automatic test_full_pop_push();
      cycle(1'b1, 8'h06, 1'b1, 1'b0);
      vectors++;
      if (level !== 3'd4) begin
         errors++;
         $display("FAIL full_pop_only: level got %0d want 4", level);
      end
      cycle(1'b1, 8'h06, 1'b0, 1'b0);
      vectors++;
      if (level !== 3'd5) begin
         errors++;
         $display("FAIL full_push_next: level got %0d want 5", level);
      end
      for (int i = 0; i < 20 && (m_lvl != 0); i++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if ({out_valid, level, almost_full, almost_empty, in_ready} !== exp_status()) begin
            errors++;
            $display("FAIL full_drain_status: got %b want %b",
                     {out_valid, level, almost_full, almost_empty, in_ready}, exp_status());
         end
         if (m_ov) begin
            vectors++;
            if (dout !== m_od) begin
               errors++;
               $display("FAIL full_drain_data: got %h want %h", dout, m_od);
            end
         end
      end
      vectors++;
      if (got.size() != 6) begin
         errors++;
         $display("FAIL full_order_count: got %0d words want 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got[i] !== 8'(i + 1)) begin
               errors++;
               $display("FAIL full_order[%0d]: got %h want %h", i, got[i], 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_random_stream();
      int   np;
      logic iv, ordy;
      np = 0;
      got.delete();
      for (int c = 0; c < 400 && !(np == 20 && m_lvl == 0); c++) begin
         iv   = (np < 20) && ($urandom % 4 != 0);
         ordy = ($urandom % 3 != 0);
         if (iv && m_lvl < 5) begin
            cycle(1'b1, 8'h40 + 8'(np), ordy, 1'b0);
            np++;
         end else begin
            cycle(iv, 8'h40 + 8'(np), ordy, 1'b0);
         end
         vectors++;
         if ({out_valid, level, almost_full, almost_empty, in_ready} !== exp_status()) begin
            errors++;
            $display("FAIL stream_status c%0d: got %b want %b", c,
                     {out_valid, level, almost_full, almost_empty, in_ready}, exp_status());
         end
         if (m_ov) begin
            vectors++;
            if (dout !== m_od) begin
               errors++;
               $display("FAIL stream_data c%0d: got %h want %h", c, dout, m_od);
            end
         end
      end
      vectors++;
      if (np != 20 || m_lvl != 0 || got.size() != 20) begin
         errors++;
         $display("FAIL stream_budget: pushed %0d popped %0d want 20/20", np, got.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            vectors++;
            if (got[i] !== 8'h40 + 8'(i)) begin
               errors++;
               $display("FAIL stream_order[%0d]: got %h want %h", i, got[i], 8'h40 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'($urandom % 2), 1'b1);
      vectors++;
      if ({out_valid, level, almost_full, almost_empty, in_ready} !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL flush_state: got %b want 0000010",
                  {out_valid, level, almost_full, almost_empty, in_ready});
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if ({out_valid, level, almost_full, almost_empty, in_ready} !== exp_status()) begin
            errors++;
            $display("FAIL flush_after%0d: got %b want %b", i,
                     {out_valid, level, almost_full, almost_empty, in_ready}, exp_status());
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      vectors++;
      if (level !== 3'd3) begin
         errors++;
         $display("FAIL areset_setup: level got %0d want 3", level);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({out_valid, level, almost_full, almost_empty, in_ready, dout} !== {7'b0_000_0_1_1, 8'h00}) begin
         errors++;
         $display("FAIL areset_immediate: got %b/%h want 0000011/00",
                  {out_valid, level, almost_full, almost_empty, in_ready}, dout);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== BYP) begin
         errors++;
         $display("FAIL areset_lat_e0: out_valid got %b want %b", out_valid, BYP);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      vectors++;
      if ({out_valid, dout, level} !== {1'b1, 8'h5A, 3'd1}) begin
         errors++;
         $display("FAIL areset_lat_e1: got v=%b out=%h lvl=%0d want v=1 out=5a lvl=1",
                  out_valid, dout, level);
      end
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_fill();
      test_full_pop_push();
      test_random_stream();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/gfx_fifo_level.md
# gfx_fifo_level

Parametrised single-clock FIFO for the gfx pipeline: any depth ≥2 (including non-power-of-two), occupancy output, registered almost-full/almost-empty flags, and a synchronous flush. It buffers between gfx stages where the producer must throttle before backpressure arrives, or where a stage must drop queued work on a pipeline restart. Storage is a RAM array plus one registered output stage, so no combinational path runs from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, 32: payload bits.
- `DEPTH`, 16: total capacity in words, including the output stage; ≥2, any integer.
- `ALMOST_FULL`, DEPTH-2: `almost_full` asserts when level ≥ this value; 1..DEPTH.
- `ALMOST_EMPTY`, 1: `almost_empty` asserts when level ≤ this value; 0..DEPTH-1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous discard of all contents.
- `in`  in  WIDTH  write payload.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO accepts a word this cycle.
- `out_ready`  in  1  consumer takes a word.
- `out_valid`  out  1  `out` holds the oldest word.
- `out`  out  WIDTH  head payload, registered.
- `level`  out  $clog2(DEPTH+1)  words held, registered.
- `almost_full`  out  1  registered threshold flag.
- `almost_empty`  out  1  registered threshold flag.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `in_ready = !flush && level < DEPTH`. It depends only on registered state and `flush`, never on `out_ready`.
- Storage: RAM of DEPTH-1 entries, plus a one-word output register (`out`, `out_valid`).
- Write and read pointers count 0..DEPTH-2 and wrap to 0. No power-of-two arithmetic.
- The output register refills from the RAM head when it is empty, or when it pops in the same cycle and the RAM is non-empty.
- A pushed word lands in RAM. It never goes straight into the output register unless bypass is compiled in (see Configuration).
- Level: `level_next = level + push - pop`. Simultaneous push and pop keep the level unchanged. Flags are computed from `level_next` and registered together with `level`.
- Flush: on an edge with `flush` high:
  - pointers, `level` and `out_valid` go to 0;
  - `almost_empty` goes to 1 and `almost_full` goes to 0;
  - any pop that cycle still completes for the consumer, but the word is not re-presented;
  - no push happens (`in_ready` is 0).
  - RAM contents are don't-care.
- Reset values: `out_valid`=0, `level`=0, `almost_full`=0, `almost_empty`=1, pointers 0, `out`=0. `in_ready`=1 while `flush`=0.
- Reset mid-transfer discards everything. The first edge after deassertion behaves as from empty.
- `out` and `out_valid` stay stable while `out_valid && !out_ready`.

## Timing
- Without bypass:
  - a word pushed at edge E into an empty FIFO reaches the RAM at E;
  - it is loaded into the output register at E+1, so `out_valid` is high after E+1.
  - First-word latency is 2 edges.
- Steady state with a non-empty RAM: one pop per cycle, full throughput, no bubbles.
- At full (level=DEPTH), `in_ready` is 0. A pop at edge E makes `in_ready` 1 after E. There is no same-cycle pass-through at full.
- At empty, `out_valid` is 0 and `out_ready` is ignored.
- `level` and the flags update on the same edge as the push/pop that changes them.

## Configuration
- `GFX_FIFO_BYPASS_EN` defined: a push into a FIFO whose RAM is empty, while the output register is empty or popping that cycle, writes directly into the output register.
  - First-word latency becomes 1 edge.
  - Level accounting is unchanged.
- Not defined: every word passes through the RAM, giving 2-edge first-word latency as in Timing.

## Structure
- No new package typedefs. `PTR_W` and `LVL_W` are localparams derived from DEPTH.
- One sub-module, `gfx_fifo_ram`:
  - DEPTH-1 × WIDTH simple dual-port array;
  - one write port, one synchronous read port with read-enable;
  - no reset on contents.
- The top level holds the pointers, level counter, flags, flush logic and output register.

## Test plan
All scenarios use WIDTH=8, DEPTH=5, ALMOST_FULL=4, ALMOST_EMPTY=1.
- Reset, then push 0x11 with `out_ready`=0 → `out_valid` high 2 edges later (1 with bypass), `out`=0x11, `level`=1, `almost_empty`=1.
- Push 0x01..0x05 with no pops → `level`=5, `in_ready`=0, `almost_full` asserted after the 4th push. A 6th `in_valid` is not accepted.
- At full, pop and push in the same cycle → one pop that cycle with `in_ready`=0. The next cycle accepts the push; order 0x01..0x06 is preserved.
- Continuous push and pop for 20 words with random `out_ready` stalls → in-order output, `level` never exceeds 5, pointers wrap correctly on non-power-of-two storage.
- Three words queued, `flush` pulsed one cycle with `in_valid`=1 → `level`=0, `out_valid`=0, `almost_empty`=1, and the word presented during flush is not stored.
- Assert `rst` asynchronously mid-stream with level=3 → all outputs take their reset values immediately. The next push sees 2-edge latency.
